// File: rtl/lsu_pkg.sv
// Shared load/store-unit definitions: issue FSM states, queue entry layout and
// the memory widths used by the data memory and the reservation stations.
package lsu_pkg;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 4;
    localparam int DEPTH  = 4;

    typedef enum logic [2:0] {
        IDLE,
        ST_WR,
        ST_WAIT,
        LD_RD,
        LD_BC
    } state_e;

    typedef struct packed {
        logic              is_store;
        logic [TAG_W-1:0]  tag;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

endpackage

// File: rtl/lsq_fifo.sv
// Synchronous FIFO holding pending load/store entries; the head entry is
// visible combinationally so the issuer can act on it without an extra cycle.
module lsq_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 46
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Pointers are exactly log2(DEPTH) bits, so increments wrap modulo DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/lsu_mem_issuer.sv
// In-order load/store issuer: drains the entry queue head-first into the data
// memory port and broadcasts load results on the CDB.
module lsu_mem_issuer #(
    parameter int DEPTH  = lsu_pkg::DEPTH,
    parameter int TAG_W  = lsu_pkg::TAG_W,
    parameter int ADDR_W = lsu_pkg::ADDR_W,
    parameter int DATA_W = lsu_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_is_store,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    output logic              mem_wena,
    output logic [ADDR_W-1:0] mem_addrL,
    output logic [ADDR_W-1:0] mem_addrS,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic              mem_fns,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              cdb_valid,
    input  logic              cdb_ready,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_data,
    output logic              busy
);
    import lsu_pkg::*;

    localparam int EW = 1 + TAG_W + ADDR_W + DATA_W;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [EW-1:0]     push_entry, head_entry;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full, fifo_empty, push, pop;
    logic              head_is_store;
    logic [TAG_W-1:0]  head_tag;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    state_e            state_q, state_d;
    logic              mem_wena_q, mem_wena_d;
    logic [ADDR_W-1:0] mem_addrL_q, mem_addrL_d;
    logic [ADDR_W-1:0] mem_addrS_q, mem_addrS_d;
    logic [DATA_W-1:0] mem_data_in_q, mem_data_in_d;
    logic              cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0] cdb_data_q, cdb_data_d;

    assign push       = in_valid && in_ready;
    assign push_entry = {in_is_store, in_tag, in_addr, in_data};

    lsq_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head_entry),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign head_is_store = head_entry[EW-1];
    assign head_tag      = head_entry[ADDR_W+DATA_W +: TAG_W];
    assign head_addr     = head_entry[DATA_W +: ADDR_W];
    assign head_data     = head_entry[DATA_W-1:0];

    // Memory-port outputs are computed one state ahead so that they are
    // registered and valid for exactly the cycle spent in the issuing state.
    always_comb begin
        state_d       = state_q;
        pop           = 1'b0;
        mem_wena_d    = 1'b0;
        mem_addrS_d   = '0;
        mem_data_in_d = '0;
        mem_addrL_d   = '0;
        cdb_valid_d   = cdb_valid_q;
        cdb_tag_d     = cdb_tag_q;
        cdb_data_d    = cdb_data_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    if (head_is_store) begin
                        state_d       = ST_WR;
                        mem_wena_d    = 1'b1;
                        mem_addrS_d   = head_addr;
                        mem_data_in_d = head_data;
                    end else begin
                        state_d     = LD_RD;
                        mem_addrL_d = head_addr;
                    end
                end
            end
            ST_WR: state_d = ST_WAIT;
            ST_WAIT: begin
                if (mem_fns) begin
                    pop     = 1'b1;
                    state_d = IDLE;
                end
            end
            LD_RD: begin
                cdb_valid_d = 1'b1;
                cdb_tag_d   = head_tag;
                cdb_data_d  = mem_data_out;
                state_d     = LD_BC;
            end
            LD_BC: begin
                if (cdb_ready) begin
                    pop         = 1'b1;
                    cdb_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            mem_wena_q    <= 1'b0;
            mem_addrL_q   <= '0;
            mem_addrS_q   <= '0;
            mem_data_in_q <= '0;
            cdb_valid_q   <= 1'b0;
            cdb_tag_q     <= '0;
            cdb_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            mem_wena_q    <= mem_wena_d;
            mem_addrL_q   <= mem_addrL_d;
            mem_addrS_q   <= mem_addrS_d;
            mem_data_in_q <= mem_data_in_d;
            cdb_valid_q   <= cdb_valid_d;
            cdb_tag_q     <= cdb_tag_d;
            cdb_data_q    <= cdb_data_d;
        end
    end

    assign in_ready    = !fifo_full;
    assign busy        = (fifo_count != '0) || (state_q != IDLE);
    assign mem_wena    = mem_wena_q;
    assign mem_addrL   = mem_addrL_q;
    assign mem_addrS   = mem_addrS_q;
    assign mem_data_in = mem_data_in_q;
    assign cdb_valid   = cdb_valid_q;
    assign cdb_tag     = cdb_tag_q;
    assign cdb_data    = cdb_data_q;

endmodule

// File: tb/tb_lsu_mem_issuer.sv
// Directed bench for lsu_mem_issuer with a program-order reference model and
// a behavioural 512-word data memory (word i initialised to i, address 0 read-only).
module tb_lsu_mem_issuer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid, in_ready, in_is_store;
    logic [3:0]  in_tag;
    logic [8:0]  in_addr;
    logic [31:0] in_data;
    logic        mem_wena, mem_fns;
    logic [8:0]  mem_addrL, mem_addrS;
    logic [31:0] mem_data_in, mem_data_out;
    logic        cdb_valid, cdb_ready, busy;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_data;

    always #5 clk = ~clk;

    lsu_mem_issuer #(.DEPTH(4), .TAG_W(4), .ADDR_W(9), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_is_store(in_is_store),
        .in_tag(in_tag), .in_addr(in_addr), .in_data(in_data),
        .mem_wena(mem_wena), .mem_addrL(mem_addrL), .mem_addrS(mem_addrS),
        .mem_data_in(mem_data_in), .mem_fns(mem_fns), .mem_data_out(mem_data_out),
        .cdb_valid(cdb_valid), .cdb_ready(cdb_ready), .cdb_tag(cdb_tag),
        .cdb_data(cdb_data), .busy(busy)
    );

    // Data memory: writes on a wena edge (address 0 discarded), finish flag one cycle later.
    logic [31:0] env_mem [512];
    logic        fns_q;
    assign mem_fns      = fns_q;
    assign mem_data_out = env_mem[mem_addrL];

    initial begin
        for (int i = 0; i < 512; i++) env_mem[i] = 32'(i);
        forever begin
            @(posedge clk);
            if (!rst && mem_wena && mem_addrS != 9'd0) env_mem[mem_addrS] <= mem_data_in;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) fns_q <= 1'b0;
        else     fns_q <= mem_wena;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: every accepted entry is resolved against the model memory
    // in program order, giving the exact write and broadcast sequences expected.
    typedef struct { logic [8:0] addr; logic [31:0] data; } wr_t;
    typedef struct { logic [3:0] tag;  logic [31:0] data; } ld_t;
    wr_t         exp_wr[$];
    ld_t         exp_ld[$];
    ld_t         ld_log[$];
    logic [31:0] model_mem [512];
    int          occ;
    int          wena_cnt = 0;
    logic        wena_prev;
    time         grant_edge = 0;
    time         wena_edge  = 0;

    initial begin
        for (int i = 0; i < 512; i++) model_mem[i] = 32'(i);
        occ = 0;
        wena_prev = 1'b0;
        forever begin
            @(negedge clk or posedge rst);
            if (rst) begin
                exp_wr.delete();
                exp_ld.delete();
                occ = 0;
                wena_prev = 1'b0;
            end else begin
                check("in_ready", in_ready, 64'(occ < 4));
                check("busy", busy, 64'(occ != 0));
                if (mem_wena) begin
                    if (!wena_prev) begin
                        wena_cnt++;
                        wena_edge = $time - 5;
                    end
                    check("store_pending", 64'(exp_wr.size() > 0), 1);
                    if (exp_wr.size() > 0) begin
                        check("st_addr", mem_addrS, exp_wr[0].addr);
                        check("st_data", mem_data_in, exp_wr[0].data);
                        void'(exp_wr.pop_front());
                    end
                end else begin
                    check("st_port_idle", {mem_addrS, mem_data_in}, 0);
                end
                if (cdb_valid) begin
                    check("load_pending", 64'(exp_ld.size() > 0), 1);
                    if (exp_ld.size() > 0) begin
                        check("cdb_tag", cdb_tag, exp_ld[0].tag);
                        check("cdb_data", cdb_data, exp_ld[0].data);
                    end
                    if (cdb_ready) begin
                        ld_log.push_back('{cdb_tag, cdb_data});
                        grant_edge = $time + 5;
                        if (exp_ld.size() > 0) void'(exp_ld.pop_front());
                    end
                end
                if (in_valid && in_ready) begin
                    occ++;
                    if (in_is_store) begin
                        exp_wr.push_back('{in_addr, in_data});
                        if (in_addr != 9'd0) model_mem[in_addr] = in_data;
                    end else begin
                        exp_ld.push_back('{in_tag, model_mem[in_addr]});
                    end
                end
                if (cdb_valid && cdb_ready) occ--;
                if (mem_fns) occ--;
                wena_prev = mem_wena;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the edge that accepted the entry.
    task automatic push(input logic st, input logic [3:0] tag, input logic [8:0] addr,
                        input logic [31:0] data);
        int  n = 0;
        logic acc = 1'b0;
        in_valid = 1'b1; in_is_store = st; in_tag = tag; in_addr = addr; in_data = data;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 100);
        if (!acc) check("push_accept_bound", acc, 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || exp_ld.size() != 0 || exp_wr.size() != 0) && n < 200);
        if (n >= 200) check("wait_idle_bound", 64'(busy), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    int w0, n0;

    initial begin
        in_valid = 0; in_is_store = 0; in_tag = 0; in_addr = 0; in_data = 0; cdb_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_wena", mem_wena, 0);
        check("rst_addrS", mem_addrS, 0);
        check("rst_addrL", mem_addrL, 0);
        check("rst_data_in", mem_data_in, 0);
        check("rst_cdb_valid", cdb_valid, 0);
        check("rst_cdb_tag", cdb_tag, 0);
        check("rst_cdb_data", cdb_data, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single load: tag 3 from address 5.
        cdb_ready = 1'b1;
        push(1'b0, 4'd3, 9'd5, 32'd0);
        @(negedge clk); check("ld_E0_cdb_valid", cdb_valid, 0);
        @(negedge clk); check("ld_E1_addrL", mem_addrL, 5);
                        check("ld_E1_cdb_valid", cdb_valid, 0);
        @(negedge clk); check("ld_E2_cdb_valid", cdb_valid, 1);
                        check("ld_E2_cdb_tag", cdb_tag, 3);
                        check("ld_E2_cdb_data", cdb_data, 32'h5);
        @(negedge clk); check("ld_E3_busy", busy, 0);
                        check("ld_E3_cdb_valid", cdb_valid, 0);
        @(posedge clk); #1;

        // Store then load to the same address.
        w0 = wena_cnt;
        push(1'b1, 4'd0, 9'd4, 32'hDEADBEEF);
        push(1'b0, 4'd7, 9'd4, 32'd0);
        wait_idle();
        check("stld_wena_pulses", 64'(wena_cnt - w0), 1);
        check("stld_mem4", env_mem[4], 32'hDEADBEEF);
        check("stld_tag", ld_log[$].tag, 7);
        check("stld_data", ld_log[$].data, 32'hDEADBEEF);

        // Store to address 0 is issued but discarded by the memory.
        w0 = wena_cnt;
        push(1'b1, 4'd0, 9'd0, 32'h1234);
        push(1'b0, 4'd2, 9'd0, 32'd0);
        wait_idle();
        check("st0_wena_pulses", 64'(wena_cnt - w0), 1);
        check("st0_tag", ld_log[$].tag, 2);
        check("st0_data", ld_log[$].data, 32'h0);

        // Full queue with the CDB withheld.
        cdb_ready = 1'b0;
        for (int t = 1; t <= 4; t++) push(1'b0, 4'(t), 9'(9 + t), 32'd0);
        @(negedge clk); check("full_in_ready", in_ready, 0);
        @(posedge clk); #1;
        in_valid = 1'b1; in_is_store = 1'b0; in_tag = 4'd9; in_addr = 9'd99;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); check("full_reject", in_ready, 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n0 = ld_log.size();
        cdb_ready = 1'b1;
        wait_idle();
        check("full_grants", 64'(ld_log.size() - n0), 4);
        for (int i = 0; i < 4; i++) begin
            if (n0 + i < ld_log.size()) begin
                check("full_order_tag", ld_log[n0 + i].tag, 64'(i + 1));
                check("full_order_data", ld_log[n0 + i].data, 64'(10 + i));
            end
        end

        // Back-pressure in LD_BC while a store waits behind the load.
        cdb_ready = 1'b0;
        w0 = wena_cnt;
        push(1'b0, 4'd5, 9'd20, 32'd0);
        push(1'b1, 4'd0, 9'd21, 32'h0000ABCD);
        repeat (5) @(posedge clk);
        #1;
        check("bp_store_held", 64'(wena_cnt - w0), 0);
        cdb_ready = 1'b1;
        wait_idle();
        check("bp_wena_pulses", 64'(wena_cnt - w0), 1);
        check("bp_wena_after_grant", 64'(wena_edge - grant_edge), 10);
        check("bp_ld_tag", ld_log[$].tag, 5);
        check("bp_ld_data", ld_log[$].data, 32'd20);
        check("bp_mem21", env_mem[21], 32'h0000ABCD);

        // Reset asserted while the store is in ST_WR.
        push(1'b1, 4'd0, 9'd30, 32'h5555);
        @(negedge clk);
        @(negedge clk); check("rst_mid_wena_before", mem_wena, 1);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_wena", mem_wena, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_in_ready", in_ready, 1);
        check("rst_mid_addrS", mem_addrS, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mid_mem30", env_mem[30], 32'd30);
        check("rst_mid_idle", busy, 0);
        check("queues_drained", 64'(exp_wr.size() + exp_ld.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
